proc_param: RTL
===============

# proc_param

Parametrised multicycle processor, the next generation of the team's 9-bit four-step datapath. It runs an eight-opcode instruction set over a 2^REG_AW-entry register file with configurable data width, and moves every value over a single shared bus. Results of ALU operations are written back from G into Rx. It sits between the instruction/memory source driving DIN and any logic sampling BusWire/done.

## Interface
- DATA_W, 9, datapath, bus, register and instruction width
- REG_AW, 3, register-select field width; register count = 2^REG_AW; DATA_W must be ≥ 3 + 2·REG_AW (elaboration error otherwise)

- clock  in  1  sole clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- run  in  1  start request, sampled in T0
- DIN  in  DATA_W  instruction word in T0; immediate operand in T1 of mvi
- done  out  1  high for exactly the final cycle of each instruction
- BusWire  out  DATA_W  shared bus value (combinational)

## Operation
- IR fields:
  - I = IR[DATA_W-1 -: 3]
  - X = IR[DATA_W-4 -: REG_AW]
  - Y = next REG_AW bits below X
  - Remaining low bits are ignored.
- Architectural state:
  - R0..R(2^REG_AW−1), A, G, IR, all DATA_W wide.
  - Step register: T0..T3.
- Opcodes:
  - 000 mv: Rx←Ry
  - 001 mvi: Rx←DIN
  - 010 add: Rx←Rx+Ry
  - 011 sub: Rx←Rx−Ry
  - 100 and: Rx←Rx&Ry
  - 101 mvnz: Rx←Ry only if G≠0
  - 110 or: Rx←Rx|Ry
  - 111 reserved: no-op
- Steps (bus source; writes; next step):
  - T0: bus=DIN. If run: IR←DIN, go to T1. Otherwise no write, stay in T0.
  - T1, mv: bus=Ry, write Rx, done=1, go to T0.
  - T1, mvi: bus=DIN, write Rx, done=1, go to T0.
  - T1, mvnz: bus=Ry, write Rx only when G≠0, done=1, go to T0.
  - T1, reserved: bus=DIN, no write, done=1, go to T0.
  - T1, ALU ops: bus=Rx, A←bus, go to T2.
  - T2: bus=Ry, G←A op bus, go to T3.
  - T3: bus=G, Rx←G, done=1, go to T0.
- Arithmetic:
  - Results are modulo 2^DATA_W.
  - No carry or overflow output.
  - sub is A + ~bus + 1.
- X==Y is legal. Example: add R3,R3 doubles R3.
- At most one register write-enable is active per cycle.

## Timing
- Reset (synchronous, highest priority):
  - Next step is T0.
  - IR, A, G and all Rn are cleared to 0.
  - No other write occurs in that cycle.
- Outputs after reset:
  - done = 0.
  - BusWire = DIN, since the step is T0.
- Reset asserted mid-instruction aborts the instruction. No partial writeback happens, and done stays 0.
- Latency from the T0 edge that captures IR:
  - mv / mvi / mvnz / reserved: 2 cycles.
  - ALU ops: 4 cycles.
- done is decoded combinationally from the step and I. It is never high in T0 and never high for two consecutive cycles.
- run is ignored outside T0. A new instruction may be accepted in the T0 cycle immediately after a done cycle.
- For mvi, the source holds the immediate on DIN during T1. DIN is don't-care in T2 and T3.
- BusWire is driven with a defined value in every step; it is never X.

## Configuration
- PROC_MVNZ_EN, defined: opcode 101 executes mvnz as specified, and G≠0 is evaluated with the G value present at T1.
- PROC_MVNZ_EN, undefined:
  - Opcode 101 decodes as reserved: no write, done in T1.
  - The zero-detect on G is not synthesised.

## Test plan
- Reset, then mvi R0 (DIN=9'b001_000_000 with run=1, DIN=5 in T1) -> R0=5; done high only in T1; idle T0 with run=0 for 3 cycles produces no writes.
- mv R1,R0 -> BusWire=5 in T1, R1=5, done after 2 cycles; then add R0,R1 -> A=5 after T1, G=10 after T2, R0=10 at end of T3, done only in T3.
- Wrap: mvi R2=0, then sub R2,R0 (R0=10) -> R2=9'h1F6. Next, mvi R3=9'h1FF and add R3,R3 -> R3=9'h1FE.
- and/or: R4=9'h0F0, R5=9'h03C. and R4,R5 -> 9'h030. or R5,R4 (R4=9'h030 after the and, R5=9'h03C) -> 9'h03C.
- mvnz R6,R0 right after reset (G=0) -> R6 unchanged at 0. After an ALU op leaving G≠0 -> R6=R0. With PROC_MVNZ_EN undefined, R6 stays unchanged in both cases.
- Reset asserted in T2 of add -> next cycle is T0, all registers 0, done never pulses. Reserved opcode 111 -> no register changes, done in T1.

Source files
------------

// File: rtl/proc_param.sv
// proc_param: parametrised multicycle processor with an eight-opcode ISA.
// Every value moves over one shared bus (BusWire); ALU results pass A -> G -> Rx.
// Steps: T0 fetch, T1 move/operand A, T2 ALU into G, T3 writeback from G.
// Optional feature: define PROC_MVNZ_EN to execute opcode 101 as mvnz; otherwise 101 is a no-op.
module proc_param #(
  parameter int unsigned DATA_W = 9,
  parameter int unsigned REG_AW = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              run,
  input  logic [DATA_W-1:0] DIN,
  output logic              done,
  output logic [DATA_W-1:0] BusWire
);

  localparam int unsigned NumRegs = 2 ** REG_AW;
  localparam logic [DATA_W-1:0] One = {{(DATA_W-1){1'b0}}, 1'b1};

  // The instruction word must hold the opcode and both register fields.
  if (DATA_W < 3 + 2 * REG_AW) begin : gen_width_check
    $error("proc_param: DATA_W must be at least 3 + 2*REG_AW");
  end

  typedef enum logic [1:0] {StT0, StT1, StT2, StT3} step_e;

  typedef enum logic [2:0] {
    OpMv   = 3'b000,
    OpMvi  = 3'b001,
    OpAdd  = 3'b010,
    OpSub  = 3'b011,
    OpAnd  = 3'b100,
    OpMvnz = 3'b101,
    OpOr   = 3'b110,
    OpRsv  = 3'b111
  } op_e;

  step_e             step_q, step_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] g_q, g_d;
  logic [DATA_W-1:0] r_q [NumRegs];
  logic [DATA_W-1:0] r_d [NumRegs];

  op_e               op;
  logic [REG_AW-1:0] rx, ry;
  logic [DATA_W-1:0] bus;

  assign op = op_e'(ir_q[DATA_W-1 -: 3]);
  assign rx = ir_q[DATA_W-4 -: REG_AW];
  assign ry = ir_q[DATA_W-4-REG_AW -: REG_AW];
  assign BusWire = bus;

  // Bus source selection, step sequencing and all next-state values.
  always_comb begin
    bus    = DIN;
    done   = 1'b0;
    step_d = step_q;
    ir_d   = ir_q;
    a_d    = a_q;
    g_d    = g_q;
    r_d    = r_q;
    unique case (step_q)
      StT0: begin
        if (run) begin
          ir_d   = DIN;
          step_d = StT1;
        end
      end
      StT1: begin
        step_d = StT0;
        unique case (op)
          OpMv: begin
            bus     = r_q[ry];
            r_d[rx] = bus;
            done    = 1'b1;
          end
          OpMvi: begin
            r_d[rx] = bus;
            done    = 1'b1;
          end
`ifdef PROC_MVNZ_EN
          OpMvnz: begin
            bus = r_q[ry];
            // G is tested as it stands in T1, before this instruction could touch it.
            if (g_q != '0) r_d[rx] = bus;
            done = 1'b1;
          end
`else
          OpMvnz: begin
            done = 1'b1;
          end
`endif
          OpRsv: begin
            done = 1'b1;
          end
          OpAdd, OpSub, OpAnd, OpOr: begin
            bus    = r_q[rx];
            a_d    = bus;
            step_d = StT2;
          end
          default: ;
        endcase
      end
      StT2: begin
        bus    = r_q[ry];
        step_d = StT3;
        unique case (op)
          OpAdd:   g_d = a_q + bus;
          OpSub:   g_d = a_q + ~bus + One;
          OpAnd:   g_d = a_q & bus;
          OpOr:    g_d = a_q | bus;
          default: g_d = g_q;
        endcase
      end
      StT3: begin
        bus     = g_q;
        r_d[rx] = g_q;
        done    = 1'b1;
        step_d  = StT0;
      end
      default: step_d = StT0;
    endcase
  end

  // State update; synchronous reset clears everything and suppresses writeback.
  always_ff @(posedge clock) begin
    if (reset) begin
      step_q <= StT0;
      ir_q   <= '0;
      a_q    <= '0;
      g_q    <= '0;
      for (int i = 0; i < NumRegs; i++) r_q[i] <= '0;
    end else begin
      step_q <= step_d;
      ir_q   <= ir_d;
      a_q    <= a_d;
      g_q    <= g_d;
      for (int i = 0; i < NumRegs; i++) r_q[i] <= r_d[i];
    end
  end

endmodule
